// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream plus instruction-memory write port and
// pipeline boot controls for the boot-time instruction loader.
//   in_valid/in_data/in_ready  host byte handshake (byte moves on valid && ready)
//   imem_we/imem_addr/imem_wdata  one-cycle word write into instruction memory
//   core_rst/done/err  pipeline reset hold and load status
// Modports: slave = the loader, master = the host/boot side.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  core_rst;
  logic                  done;
  logic                  err;

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Takes a little-endian byte stream (4-byte word count N, then 4*N bytes),
// assembles 32-bit words and writes them to consecutive word addresses from 0.
// The pipeline is held in reset (core_rst=1) until the last word is written.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  imem_loader_if.slave (byte input, imem write port, core_rst/done/err)
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  imem_loader_if.slave    bus
);
  localparam logic [32:0] DEPTH = 33'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {S_HDR, S_LOAD, S_DONE, S_ERR} state_t;

  state_t                state_q, state_d;
  logic [1:0]            bcnt_q;
  logic [31:0]           cnt_q;
  logic [23:0]           asm_q;     // low three bytes; the 4th arrives on in_data
  logic [ADDR_WIDTH:0]   widx_q;    // one extra bit so N == depth is representable
  logic [ADDR_WIDTH:0]   widx_inc;
  logic [31:0]           hdr_n;
  logic                  fire, last_byte;
  logic                  in_ready_q, we_q, core_rst_q, done_q, err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  always_comb begin
    fire      = bus.in_valid && in_ready_q;
    last_byte = fire && (bcnt_q == 2'd3);
    hdr_n     = {bus.in_data, cnt_q[23:0]};
    widx_inc  = widx_q + (ADDR_WIDTH+1)'(1);
    state_d   = state_q;
    case (state_q)
      S_HDR: begin
        if (last_byte) begin
          if (hdr_n == 32'd0)               state_d = S_DONE;
          else if ({1'b0, hdr_n} > DEPTH)   state_d = S_ERR;
          else                              state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (last_byte && (32'(widx_inc) == cnt_q)) state_d = S_DONE;
      end
      default: state_d = state_q;   // DONE and ERR are terminal until rst
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_HDR;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q     <= '0;
      cnt_q      <= '0;
      asm_q      <= '0;
      widx_q     <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // ready follows the state being entered, so it drops the cycle after
      // the final byte and no further byte can slip in
      in_ready_q <= (state_d == S_HDR) || (state_d == S_LOAD);
      we_q       <= 1'b0;
      err_q      <= (state_d == S_ERR);
      // done/core_rst lag the DONE state by one cycle so the last write
      // lands before the core leaves reset
      done_q     <= (state_q == S_DONE);
      core_rst_q <= (state_q != S_DONE);
      if (fire) begin
        bcnt_q <= bcnt_q + 2'd1;
        if (state_q == S_HDR) begin
          case (bcnt_q)
            2'd0:    cnt_q[7:0]   <= bus.in_data;
            2'd1:    cnt_q[15:8]  <= bus.in_data;
            2'd2:    cnt_q[23:16] <= bus.in_data;
            default: begin
              cnt_q  <= hdr_n;
              widx_q <= '0;
            end
          endcase
        end else if (state_q == S_LOAD) begin
          case (bcnt_q)
            2'd0:    asm_q[7:0]   <= bus.in_data;
            2'd1:    asm_q[15:8]  <= bus.in_data;
            2'd2:    asm_q[23:16] <= bus.in_data;
            default: begin
              wdata_q <= {bus.in_data, asm_q};
              addr_q  <= widx_q[ADDR_WIDTH-1:0];
              we_q    <= 1'b1;
              widx_q  <= widx_inc;
            end
          endcase
        end
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_rst   = core_rst_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader (ADDR_WIDTH=8).
// Drives inputs on the falling edge, samples outputs on the falling edge.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(8)) ifc();
  imem_loader #(.ADDR_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(ifc));

  int          n_cmp = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  logic [31:0] mem [256];
  logic [7:0]  last_addr = '0;

  // write monitor: records every strobe seen in the middle of a cycle
  always @(negedge clk) begin
    if (ifc.imem_we === 1'b1) begin
      wr_cnt++;
      mem[ifc.imem_addr] = ifc.imem_wdata;
      last_addr = ifc.imem_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // offer one byte after 'gap' idle cycles; returns at the falling edge
  // following acceptance
  task automatic put(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_data  = b;
    n = 0;
    while (ifc.in_ready !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (ifc.in_ready !== 1'b1) begin
      chk("rdy_wait", {31'd0, ifc.in_ready}, 32'd1);
      ifc.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_rdy",   {31'd0, ifc.in_ready}, 32'd0);
    chk("rst_we",    {31'd0, ifc.imem_we},  32'd0);
    chk("rst_addr",  {24'd0, ifc.imem_addr}, 32'd0);
    chk("rst_wdata", ifc.imem_wdata, 32'd0);
    chk("rst_core",  {31'd0, ifc.core_rst}, 32'd1);
    chk("rst_done",  {31'd0, ifc.done}, 32'd0);
    chk("rst_err",   {31'd0, ifc.err},  32'd0);
    wr_cnt = 0;
    mem[0] = '0;
    mem[1] = '0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rel_rdy", {31'd0, ifc.in_ready}, 32'd1);
  endtask

  task automatic two_word(input string tag, input int gap_max);
    logic [7:0] s [12];
    s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00,
          8'h93, 8'h05, 8'h60, 8'h00};
    for (int i = 0; i < 12; i++)
      put(s[i], (i == 0 || gap_max == 0) ? 0 : $urandom_range(gap_max, 1));
    // cycle T+1
    chk({tag, "_rdy_t1"},   {31'd0, ifc.in_ready}, 32'd0);
    chk({tag, "_we_t1"},    {31'd0, ifc.imem_we},  32'd1);
    chk({tag, "_addr_t1"},  {24'd0, ifc.imem_addr}, 32'd1);
    chk({tag, "_wdata_t1"}, ifc.imem_wdata, 32'h00600593);
    chk({tag, "_done_t1"},  {31'd0, ifc.done}, 32'd0);
    chk({tag, "_core_t1"},  {31'd0, ifc.core_rst}, 32'd1);
    @(negedge clk);
    // cycle T+2
    chk({tag, "_we_t2"},   {31'd0, ifc.imem_we},  32'd0);
    chk({tag, "_done_t2"}, {31'd0, ifc.done}, 32'd1);
    chk({tag, "_core_t2"}, {31'd0, ifc.core_rst}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_nwr"},   wr_cnt, 32'd2);
    chk({tag, "_mem0"},  mem[0], 32'h00500513);
    chk({tag, "_mem1"},  mem[1], 32'h00600593);
    chk({tag, "_hold_addr"},  {24'd0, ifc.imem_addr}, 32'd1);
    chk({tag, "_hold_wdata"}, ifc.imem_wdata, 32'h00600593);
    chk({tag, "_done_stky"},  {31'd0, ifc.done}, 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;

    // two-word load, back to back
    do_reset();
    two_word("nogap", 0);

    // same stream with idle gaps
    do_reset();
    two_word("gap", 3);

    // N == 0
    do_reset();
    for (int i = 0; i < 4; i++) put(8'h00, 0);
    chk("n0_rdy_t1",  {31'd0, ifc.in_ready}, 32'd0);
    chk("n0_done_t1", {31'd0, ifc.done}, 32'd0);
    @(negedge clk);
    chk("n0_done_t2", {31'd0, ifc.done}, 32'd1);
    chk("n0_core_t2", {31'd0, ifc.core_rst}, 32'd0);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'h13;
    repeat (8) @(negedge clk);
    ifc.in_valid = 1'b0;
    #1;
    chk("n0_nwr",  wr_cnt, 32'd0);
    chk("n0_rdy",  {31'd0, ifc.in_ready}, 32'd0);
    chk("n0_done", {31'd0, ifc.done}, 32'd1);

    // N == 257 overflows a 256-word memory
    do_reset();
    put(8'h01, 0); put(8'h01, 0); put(8'h00, 0); put(8'h00, 0);
    chk("ovf_err_t1", {31'd0, ifc.err}, 32'd1);
    chk("ovf_rdy_t1", {31'd0, ifc.in_ready}, 32'd0);
    repeat (5) @(negedge clk);
    #1;
    chk("ovf_err",  {31'd0, ifc.err}, 32'd1);
    chk("ovf_core", {31'd0, ifc.core_rst}, 32'd1);
    chk("ovf_done", {31'd0, ifc.done}, 32'd0);
    chk("ovf_nwr",  wr_cnt, 32'd0);

    // N == 256 fills the whole memory
    do_reset();
    put(8'h00, 0); put(8'h01, 0); put(8'h00, 0); put(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      w = 32'hC0DE0000 | 32'(i);
      for (int k = 0; k < 4; k++) put(w[8*k +: 8], 0);
    end
    chk("full_rdy_t1", {31'd0, ifc.in_ready}, 32'd0);
    chk("full_err",    {31'd0, ifc.err}, 32'd0);
    @(negedge clk);
    chk("full_done_t2", {31'd0, ifc.done}, 32'd1);
    repeat (2) @(negedge clk);
    #1;
    chk("full_nwr",   wr_cnt, 32'd256);
    chk("full_last",  {24'd0, last_addr}, 32'h000000FF);
    chk("full_mem0",  mem[0], 32'hC0DE0000);
    chk("full_mem80", mem[8'h80], 32'hC0DE0080);
    chk("full_memff", mem[8'hFF], 32'hC0DE00FF);

    // reset mid-load aborts, then a clean reload
    do_reset();
    put(8'h02, 0); put(8'h00, 0); put(8'h00, 0); put(8'h00, 0);
    put(8'h13, 0); put(8'h05, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("abort_nwr",  wr_cnt, 32'd0);
    chk("abort_core", {31'd0, ifc.core_rst}, 32'd1);
    do_reset();
    two_word("reload", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the core's instruction memory, the write-side counterpart of the fetch stage's read-only instruction port. It accepts a byte stream from a host link (UART/JTAG bridge), assembles little-endian 32-bit instruction words and writes them sequentially into instruction memory. It holds the five-stage pipeline in reset until the image is fully loaded, then releases it so fetch starts at word 0.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width; depth = 2**ADDR_WIDTH words.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  host byte is present on in_data.
- in_data  input  8  host byte.
- in_ready  output  1  loader accepts a byte this cycle. Transfer occurs when in_valid && in_ready.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  ADDR_WIDTH  word address to write.
- imem_wdata  output  32  instruction word to write.
- core_rst  output  1  reset driven to pipeline_top. High until the load completes.
- done  output  1  load finished successfully (sticky until rst).
- err  output  1  header word count exceeded the memory depth (sticky until rst).

## Operation
- Stream format:
  - 4-byte header: word count N, little-endian, first byte = bits 7:0.
  - Then 4*N payload bytes. Each group of 4 forms one word, little-endian, first byte = bits 7:0.
- FSM states: HDR, LOAD, DONE, ERR. State after reset is HDR.
- HDR:
  - in_ready=1.
  - A 2-bit byte counter collects the 4 header bytes into a 32-bit count register.
  - On acceptance of the 4th byte, the next state is chosen as follows:
    - N == 0 → DONE.
    - N > 2**ADDR_WIDTH → ERR.
    - Otherwise → LOAD, with word index cleared to 0.
- LOAD:
  - in_ready=1.
  - Bytes shift into a 32-bit assembly register at lane = byte counter.
  - On acceptance of the 4th byte of a word:
    - imem_wdata ← assembled word, imem_addr ← word index. imem_we pulses next cycle.
    - Word index increments.
  - When the accepted word is word N-1, the next state is DONE.
- DONE: in_ready=0, done=1, core_rst=0. Further input is ignored.
- ERR: in_ready=0, err=1, core_rst=1, imem_we never asserts.
- Word index counter is ADDR_WIDTH+1 bits, so N = 2**ADDR_WIDTH is legal. The last address written is 2**ADDR_WIDTH-1 with no wrap.
- Bytes presented while in_valid=0 are not consumed. Arbitrary gaps between bytes are legal.
- Simultaneous cases:
  - rst overrides everything.
  - In_valid in the same cycle as the final-byte transition is consumed only if in_ready was 1 in that cycle.

## Timing
- Reset values (cycle after rst sampled high):
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - core_rst=1, done=0, err=0.
  - Byte counter, word index and count register are 0.
- in_ready=1 from the first cycle after rst is sampled low.
- Write latency: the 4th byte is accepted at cycle T; imem_we=1 with valid addr/wdata at T+1, for exactly one cycle. imem_addr/imem_wdata hold their values afterwards.
- Back-to-back words yield imem_we pulses at least 4 cycles apart. No internal stall is needed.
- Final word accepted at T:
  - in_ready=0 from T+1.
  - Last imem_we at T+1.
  - done=1 and core_rst=0 at T+2, so memory is written before the core leaves reset.
- N == 0: header's 4th byte at T gives in_ready=0 at T+1 and done=1, core_rst=0 at T+2.
- Overflow: header's 4th byte at T gives err=1 and in_ready=0 at T+1.
- rst asserted mid-load aborts the load:
  - State returns to HDR and core_rst=1.
  - Words already written remain in memory.
  - A fresh header is expected.

## Test plan
- Reset: hold rst 2 cycles → all outputs at reset values, core_rst=1. After release, in_ready=1 next cycle.
- Two-word load, no gaps: bytes 02 00 00 00 13 05 50 00 93 05 60 00 → writes addr0=0x00500513, addr1=0x00600593, one strobe each. done=1 and core_rst=0 two cycles after the last byte.
- Same stream with in_valid low for 1-3 random cycles between bytes → identical writes and values. No byte is consumed while in_valid=0.
- Header 00 00 00 00 → no imem_we. done=1 two cycles after the 4th byte. in_ready=0 thereafter.
- ADDR_WIDTH=8, header 01 01 00 00 (N=257) → err=1, core_rst stays 1, no imem_we, done stays 0. Header 00 01 00 00 (N=256) is accepted, and its last write is at addr 0xFF.
- rst pulse after 6 accepted bytes of the two-word load, then the full two-word stream → correct writes to addr0/addr1, done=1. No write is issued for the aborted partial word.
